sa_result_drain: RTL and testbench

- Downstream stage of the systolic-array controller. Captures the four 32-bit FP32 result words (mem_data1..4 of the 2x2 array) when the controller flags completion.
- Buffers up to two complete result sets (ping-pong banks), optionally applies ReLU, and streams the words out one per beat over a valid/ready interface to the write-back/host side.

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_bank_buf.sv | 69 ++++++
 rtl/sa_result_drain.sv | 118 +++++++++++
 tb/tb_sa_result_drain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants and drain-state encoding for the systolic-array result path.
package sa_pkg;
    localparam int DATA_W        = 32;
    localparam int NUM_RES       = 4;
    localparam int NUM_BANKS     = 2;
    localparam int IDX_W         = $clog2(NUM_RES);
    localparam int FP32_SIGN_BIT = 31;

    localparam logic [31:0] FP32_ZERO = 32'h00000000;
    localparam logic [31:0] FP_ONE    = 32'h3f800000;
    localparam logic [31:0] FP_TWO    = 32'h40000000;
    localparam logic [31:0] FP_THREE  = 32'h40400000;
    localparam logic [31:0] FP_FOUR   = 32'h40800000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_e;
endpackage

// File: rtl/sa_bank_buf.sv
// Ping-pong result-set storage: two banks of NUM_RES words, each with a full flag
// and a captured ReLU flag, written at wr_ptr and read/released at rd_ptr.
module sa_bank_buf #(
    parameter int DATA_W    = 32,
    parameter int NUM_RES   = 4,
    parameter int NUM_BANKS = 2,
    parameter int IDX_W     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cap_i,
    input  logic [NUM_RES-1:0][DATA_W-1:0]  cap_words_i,
    input  logic                            cap_relu_i,
    input  logic                            rel_i,
    input  logic [IDX_W-1:0]                rd_idx_i,
    output logic [DATA_W-1:0]               rd_word_o,
    output logic                            rd_relu_o,
    output logic                            rd_full_o,
    output logic                            other_full_o,
    output logic                            any_full_o,
    output logic                            free_o
);
    logic [NUM_BANKS-1:0][NUM_RES-1:0][DATA_W-1:0] data_q;
    logic [NUM_BANKS-1:0]                          relu_q;
    logic [NUM_BANKS-1:0]                          full_q, full_d;
    logic                                          wr_ptr_q, wr_ptr_d;
    logic                                          rd_ptr_q, rd_ptr_d;

    // Capture always targets an empty bank and release a full one, so they never collide.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cap_i) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (rel_i) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_i) begin
            data_q[wr_ptr_q] <= cap_words_i;
            relu_q[wr_ptr_q] <= cap_relu_i;
        end
    end

    assign rd_word_o    = data_q[rd_ptr_q][rd_idx_i];
    assign rd_relu_o    = relu_q[rd_ptr_q];
    assign rd_full_o    = full_q[rd_ptr_q];
    assign other_full_o = full_q[~rd_ptr_q];
    assign any_full_o   = |full_q;
    assign free_o       = ~(&full_q);
endmodule

// File: rtl/sa_result_drain.sv
// Captures 2x2 systolic-array result sets into a ping-pong buffer and streams
// them out one word per beat, with optional ReLU on the output path.
module sa_result_drain #(
    parameter int DATA_W    = sa_pkg::DATA_W,
    parameter int NUM_RES   = sa_pkg::NUM_RES,
    parameter int NUM_BANKS = sa_pkg::NUM_BANKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res0,
    input  logic [DATA_W-1:0] res1,
    input  logic [DATA_W-1:0] res2,
    input  logic [DATA_W-1:0] res3,
    input  logic              relu_on,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);
    import sa_pkg::*;

    localparam int                 IW       = $clog2(NUM_RES);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_RES - 1);

    drain_state_e  state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          overflow_q, overflow_d;

    logic              cap, rel;
    logic [DATA_W-1:0] rd_word;
    logic              rd_relu, rd_full, other_full, any_full, bank_free;

    // Negative words, including -0.0 and negative NaN, clamp to +0.0.
    function automatic logic [DATA_W-1:0] relu_fn(input logic [DATA_W-1:0] w,
                                                  input logic en);
        return (en && w[FP32_SIGN_BIT]) ? DATA_W'(FP32_ZERO) : w;
    endfunction

    assign res_ready = bank_free;
    assign cap       = res_valid && bank_free;

    sa_bank_buf #(
        .DATA_W   (DATA_W),
        .NUM_RES  (NUM_RES),
        .NUM_BANKS(NUM_BANKS),
        .IDX_W    (IW)
    ) u_bank_buf (
        .clk         (clk),
        .reset       (reset),
        .cap_i       (cap),
        .cap_words_i ({res3, res2, res1, res0}),
        .cap_relu_i  (relu_on),
        .rel_i       (rel),
        .rd_idx_i    (idx_q),
        .rd_word_o   (rd_word),
        .rd_relu_o   (rd_relu),
        .rd_full_o   (rd_full),
        .other_full_o(other_full),
        .any_full_o  (any_full),
        .free_o      (bank_free)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rel        = 1'b0;
        out_valid  = 1'b0;
        overflow_d = overflow_q | (res_valid & ~bank_free);
        case (state_q)
            ST_IDLE: begin
                if (rd_full) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Chain straight into the other bank only if it was already full.
                        rel     = 1'b1;
                        idx_d   = '0;
                        state_d = other_full ? ST_STREAM : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data = out_valid ? relu_fn(rd_word, rd_relu) : '0;
    assign out_idx  = 2'(idx_q);
    assign out_last = out_valid && (idx_q == LAST_IDX);
    assign busy     = any_full || (state_q == ST_STREAM);
    assign overflow = overflow_q;
endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: drain order, stall, ReLU, double buffering,
// overflow, reset mid-stream and same-edge capture/release.
module tb_sa_result_drain;
    import sa_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res0 = '0, res1 = '0, res2 = '0, res3 = '0;
    logic        relu_on = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    sa_result_drain dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3), .relu_on(relu_on),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, b, c, d);
        res0 = a; res1 = b; res2 = c; res3 = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rst_res_ready got=%b exp=1", res_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        checks++; if (out_idx !== 2'd0 || out_last !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL rst_out idx=%0d last=%b data=%h exp 0/0/0", out_idx, out_last, out_data); end
    endtask

    task automatic test_basic_drain();
        logic [31:0] exp [4] = '{FP_ONE, FP_TWO, FP_THREE, FP_FOUR};
        out_ready = 1'b1;
        load(FP_ONE, FP_TWO, FP_THREE, FP_FOUR);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_bubble valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i) || out_last !== (i == 3)) begin
                failures++;
                $display("FAIL basic_word%0d valid=%b data=%h idx=%0d last=%b exp 1/%h/%0d/%b", i, out_valid, out_data, out_idx, out_last, exp[i], i, (i == 3));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_end valid=%b busy=%b exp 0/0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4] = '{FP_ONE, FP_TWO, FP_THREE, FP_FOUR};
        out_ready = 1'b0;
        load(FP_ONE, FP_TWO, FP_THREE, FP_FOUR);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== FP_ONE || out_idx !== 2'd0 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_cyc%0d valid=%b data=%h idx=%0d last=%b exp 1/%h/0/0", i, out_valid, out_data, out_idx, out_last, FP_ONE);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i)) begin
                failures++;
                $display("FAIL stall_word%0d valid=%b data=%h idx=%0d exp 1/%h/%0d", i, out_valid, out_data, out_idx, exp[i], i);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_end valid=%b exp=0", out_valid); end
    endtask

    task automatic test_relu();
        logic [31:0] in_w  [4] = '{32'hc0400000, 32'h40000000, 32'h80000000, 32'hbf800000};
        logic [31:0] exp_r [4] = '{32'h00000000, 32'h40000000, 32'h00000000, 32'h00000000};
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            relu_on = (pass == 0);
            load(in_w[0], in_w[1], in_w[2], in_w[3]);
            res_valid = 1'b1; tick(); res_valid = 1'b0; relu_on = 1'b0;
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== ((pass == 0) ? exp_r[i] : in_w[i])) begin
                    failures++;
                    $display("FAIL relu%0d_word%0d valid=%b data=%h exp 1/%h", pass, i, out_valid, out_data, (pass == 0) ? exp_r[i] : in_w[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_double_buffer_overflow();
        logic [31:0] exp [8] = '{FP_ONE, FP_TWO, FP_THREE, FP_FOUR,
                                 32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
        out_ready = 1'b0;
        res_valid = 1'b1;
        load(exp[0], exp[1], exp[2], exp[3]); tick();
        checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL dbl_ready_after_A got=%b exp=1", res_ready); end
        load(exp[4], exp[5], exp[6], exp[7]); tick();
        checks++; if (res_ready !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL dbl_after_B ready=%b ovf=%b exp 0/0", res_ready, overflow); end
        load(32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef); tick();
        res_valid = 1'b0;
        checks++; if (overflow !== 1'b1 || res_ready !== 1'b0) begin failures++; $display("FAIL dbl_overflow ovf=%b ready=%b exp 1/0", overflow, res_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i % 4) || out_last !== ((i % 4) == 3)) begin
                failures++;
                $display("FAIL dbl_word%0d valid=%b data=%h idx=%0d last=%b exp 1/%h/%0d/%b", i, out_valid, out_data, out_idx, out_last, exp[i], i % 4, (i % 4) == 3);
            end
            tick();
        end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL dbl_end valid=%b busy=%b ovf=%b exp 0/0/1", out_valid, busy, overflow); end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] exp [4] = '{32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
        out_ready = 1'b1;
        load(FP_FOUR, FP_THREE, FP_TWO, FP_ONE);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_idx !== 2'd2 || out_data !== FP_TWO) begin failures++; $display("FAIL mid_pre idx=%0d data=%h exp 2/%h", out_idx, out_data, FP_TWO); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL mid_reset valid=%b busy=%b ready=%b ovf=%b exp 0/0/1/0", out_valid, busy, res_ready, overflow); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_leftover valid=%b exp=0", out_valid); end
        load(exp[0], exp[1], exp[2], exp[3]);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i)) begin
                failures++;
                $display("FAIL mid_new_word%0d valid=%b data=%h idx=%0d exp 1/%h/%0d", i, out_valid, out_data, out_idx, exp[i], i);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle_capture_release();
        logic [31:0] exp [8] = '{FP_ONE, FP_TWO, FP_THREE, FP_FOUR,
                                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        out_ready = 1'b1;
        load(exp[0], exp[1], exp[2], exp[3]);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (out_last !== 1'b1 || out_data !== FP_FOUR || res_ready !== 1'b1) begin failures++; $display("FAIL same_pre last=%b data=%h ready=%b exp 1/%h/1", out_last, out_data, res_ready, FP_FOUR); end
        load(exp[4], exp[5], exp[6], exp[7]);
        res_valid = 1'b1; tick(); res_valid = 1'b0;
        // Other bank was not yet full on the release edge, so one IDLE beat precedes the new set.
        checks++; if (overflow !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL same_edge ovf=%b busy=%b valid=%b exp 0/1/0", overflow, busy, out_valid); end
        tick();
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i - 4)) begin
                failures++;
                $display("FAIL same_word%0d valid=%b data=%h idx=%0d exp 1/%h/%0d", i - 4, out_valid, out_data, out_idx, exp[i], i - 4);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1) begin failures++; $display("FAIL same_end valid=%b busy=%b ready=%b exp 0/0/1", out_valid, busy, res_ready); end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_relu();
        test_double_buffer_overflow();
        test_reset_mid_stream();
        test_same_cycle_capture_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
